// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - 8N1 MIDI serial receiver with mid-bit sampling and framing checks
module midi_uart_rx #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 31250,
    parameter int DATA_BITS       = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clock_50_000_000,
    input  logic                 reset_l,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_ready,
    output logic                 framing_error
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       clk_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   half_hit;
    logic                   full_hit;
    logic                   shift_en;
    logic                   load_byte;
    logic                   stop_bad;

    // Preset to idle-high so reset never looks like a start edge.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign half_hit = (clk_cnt == CNT_W'(HALF_BIT - 1));
    assign full_hit = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_en     = 1'b0;
        load_byte    = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (half_hit) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (full_hit) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (full_hit) begin
                    if (rx_s) begin
                        load_byte  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must go high before another frame can start.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            state          <= state_next;
            bit_idx        <= bit_idx_next;
            data_out_ready <= load_byte;
            framing_error  <= stop_bad;
            // Restart the bit timer on every state change and after each data sample.
            if (state_next != state || shift_en) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
            if (load_byte) begin
                data_out <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - directed self-checking bench for midi_uart_rx
module tb_midi_uart_rx;

    localparam int CPB = 1600;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rdy;
    logic       fe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [7:0] got_q[$];
    int         at_q[$];

    always #10 clk = ~clk;

    midi_uart_rx #(
        .CLOCK_FREQUENCY(50_000_000),
        .BAUD_RATE(31250),
        .DATA_BITS(8),
        .SYNC_STAGES(2)
    ) dut (
        .clock_50_000_000(clk),
        .reset_l(rst_l),
        .rx_serial(rx),
        .data_out(data_out),
        .data_out_ready(rdy),
        .framing_error(fe)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy) begin
            got_q.push_back(data_out);
            at_q.push_back(cyc);
        end
        if (fe) fe_cnt++;
        if (rdy && fe) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int cpb, input logic stop);
        hold(1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(b[i], cpb);
        hold(stop, cpb);
    endtask

    int base;
    int fe0;
    int fall;
    int lat;
    logic [7:0] vec[3];

    initial begin
        vec[0] = 8'h90;
        vec[1] = 8'h3C;
        vec[2] = 8'h7F;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_fe", 32'(fe), 32'h0);
        rst_l = 1'b1;
        hold(1'b1, 100);

        // single byte and its latency
        base = got_q.size();
        fall = cyc;
        send(8'h90, CPB, 1'b1);
        hold(1'b1, 2000);
        check("one_cnt", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) begin
            check("one_val", 32'(got_q[base]), 32'h90);
            lat = at_q[base] - fall;
            check("one_lat", 32'(lat >= 15201 && lat <= 15204), 32'd1);
        end
        check("one_fe", 32'(fe_cnt), 32'd0);

        // back-to-back frames, no idle gap
        base = got_q.size();
        for (int i = 0; i < 3; i++) send(vec[i], CPB, 1'b1);
        hold(1'b1, 2000);
        check("b2b_cnt", 32'(got_q.size() - base), 32'd3);
        if (got_q.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("b2b_val%0d", i), 32'(got_q[base+i]), 32'(vec[i]));
            check("b2b_gap0", 32'(at_q[base+1] - at_q[base]), 32'd16000);
            check("b2b_gap1", 32'(at_q[base+2] - at_q[base+1]), 32'd16000);
        end

        // start-bit glitch
        base = got_q.size();
        fe0 = fe_cnt;
        hold(1'b0, 400);
        hold(1'b1, 3000);
        check("glitch_rdy", 32'(got_q.size() - base), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // framing error followed by long break
        base = got_q.size();
        fe0 = fe_cnt;
        send(8'h55, CPB, 1'b0);
        hold(1'b0, 5000);
        hold(1'b1, 2000);
        check("ferr_fe", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_rdy", 32'(got_q.size() - base), 32'd0);
        check("ferr_hold", 32'(data_out), 32'h7F);
        send(8'hAA, CPB, 1'b1);
        hold(1'b1, 2000);
        check("after_cnt", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("after_val", 32'(got_q[base]), 32'hAA);

        // sender rate error of -3% and +3%
        base = got_q.size();
        fe0 = fe_cnt;
        send(8'hF8, 1552, 1'b1);
        hold(1'b1, 2000);
        send(8'hF8, 1648, 1'b1);
        hold(1'b1, 2000);
        check("tol_cnt", 32'(got_q.size() - base), 32'd2);
        if (got_q.size() >= base + 2) begin
            check("tol_fast", 32'(got_q[base]), 32'hF8);
            check("tol_slow", 32'(got_q[base+1]), 32'hF8);
        end
        check("tol_fe", 32'(fe_cnt - fe0), 32'd0);

        // reset during bit 4 of 0x90
        base = got_q.size();
        fe0 = fe_cnt;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(vec[0][i], CPB);
        hold(vec[0][4], 800);
        rst_l = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_rdy", 32'(rdy), 32'h0);
        check("mid_rst_fe", 32'(fe), 32'h0);
        rst_l = 1'b1;
        hold(1'b1, CPB * 6);
        send(8'h80, CPB, 1'b1);
        hold(1'b1, 2000);
        check("post_rst_cnt", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("post_rst_val", 32'(got_q[base]), 32'h80);
        check("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
